two_port_mux_arbiter: RTL and testbench

- Shares one registered 4-bit output channel between two requesters by sequencing the select line of a four-bit 2x1 mux.
- Round-robin arbitration with a burst limit.
- Valid/ack handshake on each input; valid/ready on the output.
- Sits between two producer blocks and a single downstream consumer in the lab datapath.

---
 rtl/two_port_mux_arbiter_pkg.sv | 29 ++
 rtl/two_port_mux_arbiter_if.sv | 36 +++
 rtl/four_bit_2x1_mux.sv | 19 +
 rtl/two_port_mux_arbiter_arb_burst_counter.sv | 53 +++++
 rtl/two_port_mux_arbiter.sv | 153 +++++++++++++++
 tb/tb_two_port_mux_arbiter.sv | 275 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/two_port_mux_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// two_port_mux_arbiter_pkg
// Shared definitions for the two-port mux arbiter: FSM state encoding,
// default parameter values and small helper functions.
// The state encoding is chosen so that the GNT states already look like the
// one-hot Grant vector (GNT0=01, GNT1=10, IDLE=00).
// ---------------------------------------------------------------------------
package two_port_mux_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      GNT0 = 2'b01,
      GNT1 = 2'b10
   } arbState_t;

   localparam int DefaultWidth    = 4;
   localparam int DefaultMaxBurst = 4;

   // Bits needed to hold a burst count from 0 up to and including maxBurst.
   function automatic int countBits(input int maxBurst);
      return (maxBurst < 1) ? 1 : $clog2(maxBurst + 1);
   endfunction

   // One-hot grant seen by the outside world for a given state.
   function automatic logic [1:0] grantOf(input arbState_t s);
      return 2'(s);
   endfunction

endpackage

// File: rtl/two_port_mux_arbiter_if.sv
// ---------------------------------------------------------------------------
// two_port_mux_arbiter_if
// Bundles the requester handshakes and the output channel of the arbiter.
//   Req_0/Data_0/Ack_0  : requester 0 valid/ack handshake
//   Req_1/Data_1/Ack_1  : requester 1 valid/ack handshake
//   Out_Valid/Out_Data/Out_Ready : registered output, valid/ready
//   Select/Grant        : current mux select and one-hot grant
// master = the surrounding producers/consumer, slave = the arbiter itself.
// ---------------------------------------------------------------------------
interface two_port_mux_arbiter_if #(
   parameter int WIDTH = 4
);

   logic             Req_0;
   logic [WIDTH-1:0] Data_0;
   logic             Ack_0;
   logic             Req_1;
   logic [WIDTH-1:0] Data_1;
   logic             Ack_1;
   logic             Out_Valid;
   logic [WIDTH-1:0] Out_Data;
   logic             Out_Ready;
   logic             Select;
   logic [1:0]       Grant;

   modport master (
      output Req_0, Data_0, Req_1, Data_1, Out_Ready,
      input  Ack_0, Ack_1, Out_Valid, Out_Data, Select, Grant
   );

   modport slave (
      input  Req_0, Data_0, Req_1, Data_1, Out_Ready,
      output Ack_0, Ack_1, Out_Valid, Out_Data, Select, Grant
   );

endinterface

// File: rtl/four_bit_2x1_mux.sv
// ---------------------------------------------------------------------------
// four_bit_2x1_mux
// Plain combinational 2:1 multiplexer used to route requester data.
//   In_0, In_1 : data inputs (WIDTH bits, four by default)
//   Select     : 0 routes In_0, 1 routes In_1
//   Out        : selected data
// ---------------------------------------------------------------------------
module four_bit_2x1_mux #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] In_0,
   input  logic [WIDTH-1:0] In_1,
   input  logic             Select,
   output logic [WIDTH-1:0] Out
);

   assign Out = Select ? In_1 : In_0;

endmodule

// File: rtl/two_port_mux_arbiter_arb_burst_counter.sv
// ---------------------------------------------------------------------------
// arb_burst_counter
// Counts transfers made under the current grant, saturating at MAX_BURST.
//   Clk, Reset_n  : clock and synchronous active-low reset
//   i_clear       : clear the count (grant is changing this edge)
//   i_inc         : a transfer happens this cycle
//   o_atMax       : registered count has reached MAX_BURST
//   o_nextAtMax   : count including this cycle's transfer reaches MAX_BURST
// ---------------------------------------------------------------------------
module arb_burst_counter
   import two_port_mux_arbiter_pkg::*;
#(
   parameter int MAX_BURST = DefaultMaxBurst
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic i_clear,
   input  logic i_inc,
   output logic o_atMax,
   output logic o_nextAtMax
);

   localparam int CW = countBits(MAX_BURST);
   localparam logic [CW-1:0] MaxCount = CW'(MAX_BURST);

   logic [CW-1:0] r_count;
   logic [CW-1:0] w_countNext;

   // Next count includes the current transfer but never passes MAX_BURST,
   // so a sole requester can keep streaming without the count wrapping.
   always_comb begin
      w_countNext = r_count;
      if (i_inc && (r_count != MaxCount)) begin
         w_countNext = r_count + CW'(1);
      end
   end

   assign o_atMax     = (r_count == MaxCount);
   assign o_nextAtMax = (w_countNext == MaxCount);

   // Clear has priority over increment: a transfer made on the edge where
   // the grant changes belongs to the old grant and must not carry over.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else begin
         r_count <= w_countNext;
      end
   end

endmodule

// File: rtl/two_port_mux_arbiter.sv
// ---------------------------------------------------------------------------
// two_port_mux_arbiter
// Shares one registered output channel between two requesters by steering
// the select line of a 2:1 mux. Round-robin with a burst limit: a requester
// keeps the grant for at most MAX_BURST beats while the other one waits.
//   Clk      : rising-edge clock
//   Reset_n  : synchronous active-low reset
//   bus      : slave side of two_port_mux_arbiter_if (requester handshakes,
//              output valid/ready channel, Select and Grant)
// ---------------------------------------------------------------------------
module two_port_mux_arbiter
   import two_port_mux_arbiter_pkg::*;
#(
   parameter int WIDTH     = DefaultWidth,
   parameter int MAX_BURST = DefaultMaxBurst
) (
   input  logic Clk,
   input  logic Reset_n,
   two_port_mux_arbiter_if.slave bus
);

   arbState_t        r_state;
   arbState_t        w_nextState;
   logic             r_last;
   logic             w_nextLast;
   logic             r_select;
   logic [1:0]       r_grant;
   logic             r_outValid;
   logic [WIDTH-1:0] r_outData;

   logic             w_space;
   logic             w_ack0;
   logic             w_ack1;
   logic             w_transfer;
   logic             w_atMax;
   logic             w_nextAtMax;
   logic             w_stateChange;
   logic [WIDTH-1:0] w_muxData;

   // The output register can take a new beat when it is empty or its
   // current beat is being consumed this same cycle.
   assign w_space = !r_outValid || bus.Out_Ready;

   // Acks are held low in reset. Once a burst has saturated and the other
   // side is waiting, the holder is refused so the grant can move on.
   assign w_ack0 = Reset_n && (r_state == GNT0) && bus.Req_0 && w_space
                   && !(w_atMax && bus.Req_1);
   assign w_ack1 = Reset_n && (r_state == GNT1) && bus.Req_1 && w_space
                   && !(w_atMax && bus.Req_0);
   assign w_transfer = w_ack0 || w_ack1;

   assign w_stateChange = (w_nextState != r_state);

   arb_burst_counter #(
      .MAX_BURST (MAX_BURST)
   ) u_burstCounter (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .i_clear     (w_stateChange),
      .i_inc       (w_transfer),
      .o_atMax     (w_atMax),
      .o_nextAtMax (w_nextAtMax)
   );

   four_bit_2x1_mux #(
      .WIDTH (WIDTH)
   ) u_dataMux (
      .In_0   (bus.Data_0),
      .In_1   (bus.Data_1),
      .Select (r_select),
      .Out    (w_muxData)
   );

   // Next-state logic. Last remembers who held the grant most recently so a
   // tie out of IDLE goes to the other requester. Moving directly between
   // GNT0 and GNT1 avoids a dead cycle on handover.
   always_comb begin
      w_nextState = r_state;
      w_nextLast  = r_last;
      unique case (r_state)
         IDLE: begin
            if (bus.Req_0 && bus.Req_1) begin
               w_nextState = r_last ? GNT0 : GNT1;
            end else if (bus.Req_0) begin
               w_nextState = GNT0;
            end else if (bus.Req_1) begin
               w_nextState = GNT1;
            end
         end
         GNT0: begin
            if (bus.Req_1 && (!bus.Req_0 || w_nextAtMax)) begin
               w_nextState = GNT1;
               w_nextLast  = 1'b0;
            end else if (!bus.Req_0 && !bus.Req_1) begin
               w_nextState = IDLE;
               w_nextLast  = 1'b0;
            end
         end
         GNT1: begin
            if (bus.Req_0 && (!bus.Req_1 || w_nextAtMax)) begin
               w_nextState = GNT0;
               w_nextLast  = 1'b1;
            end else if (!bus.Req_0 && !bus.Req_1) begin
               w_nextState = IDLE;
               w_nextLast  = 1'b1;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // State register. Select and Grant are registered from the next state so
   // they are glitch-free flop outputs that always track r_state. Last starts
   // at 1 so requester 0 wins the first tie.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_state  <= IDLE;
         r_last   <= 1'b1;
         r_select <= 1'b0;
         r_grant  <= 2'b00;
      end else begin
         r_state  <= w_nextState;
         r_last   <= w_nextLast;
         r_select <= (w_nextState == GNT1);
         r_grant  <= grantOf(w_nextState);
      end
   end

   // Output register. A transfer reloads it even while the previous beat is
   // being consumed, which keeps the channel at one beat per cycle. Reset
   // drops any beat still held.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_outValid <= 1'b0;
         r_outData  <= '0;
      end else if (w_transfer) begin
         r_outValid <= 1'b1;
         r_outData  <= w_muxData;
      end else if (bus.Out_Ready) begin
         r_outValid <= 1'b0;
      end
   end

   assign bus.Ack_0     = w_ack0;
   assign bus.Ack_1     = w_ack1;
   assign bus.Out_Valid = r_outValid;
   assign bus.Out_Data  = r_outData;
   assign bus.Select    = r_select;
   assign bus.Grant     = r_grant;

endmodule

// File: tb/tb_two_port_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_two_port_mux_arbiter
// Directed bench for two_port_mux_arbiter with a cycle-level reference model.
// Inputs change one time unit after each falling edge; outputs are examined
// on falling edges, half a cycle away from the rising edge that updates them.
// ---------------------------------------------------------------------------
module tb_two_port_mux_arbiter;

   localparam int WIDTH = 4;
   localparam int MAXB  = 4;

   logic Clk     = 1'b0;
   logic Reset_n = 1'b0;

   int checks   = 0;
   int failures = 0;

   // Reference model state: who owns the channel (-1 none), who owned it
   // last, beats granted to the current owner, and the output beat held.
   int         mOwner  = -1;
   int         mLast   = 1;
   int         mBeats  = 0;
   bit         mValid  = 1'b0;
   logic [3:0] mData   = 4'h0;
   bit         modelOn = 1'b0;

   always #5 Clk = ~Clk;

   two_port_mux_arbiter_if #(.WIDTH(WIDTH)) bus ();

   two_port_mux_arbiter #(
      .WIDTH     (WIDTH),
      .MAX_BURST (MAXB)
   ) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   // Record one comparison and report it if it does not hold.
   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Drive every input of the design in one go.
   task automatic applyStimulus(input bit rn, input bit r0, input logic [3:0] d0,
                                input bit r1, input logic [3:0] d1, input bit rdy);
      Reset_n       = rn;
      bus.Req_0     = r0;
      bus.Data_0    = d0;
      bus.Req_1     = r1;
      bus.Data_1    = d1;
      bus.Out_Ready = rdy;
   endtask

   // Hold reset across one rising edge, returning just after the next
   // falling edge with reset still low so the caller can release it.
   task automatic resetPulse();
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
      @(negedge Clk);
      #1;
   endtask

   // Whether requester `who` must be acknowledged right now: it owns the
   // channel, is asking, the output has room, and it has not used up its
   // burst while the other side waits.
   function automatic bit modelAck(input int who);
      bit reqMe;
      bit reqOther;
      reqMe    = (who == 0) ? bus.Req_0 : bus.Req_1;
      reqOther = (who == 0) ? bus.Req_1 : bus.Req_0;
      return Reset_n && (mOwner == who) && reqMe && (!mValid || bus.Out_Ready)
             && !((mBeats == MAXB) && reqOther);
   endfunction

   function automatic int modelGrant();
      return (mOwner < 0) ? 0 : ((mOwner == 0) ? 1 : 2);
   endfunction

   // Advance the reference model at each rising edge from the inputs alone.
   always @(posedge Clk) begin : model
      bit a0;
      bit a1;
      bit reqMe;
      bit reqOther;
      int me;
      int nb;
      if (!Reset_n) begin
         mOwner = -1;
         mLast  = 1;
         mBeats = 0;
         mValid = 1'b0;
         mData  = 4'h0;
      end else begin
         a0 = modelAck(0);
         a1 = modelAck(1);
         if (a0 || a1) begin
            mData  = a0 ? bus.Data_0 : bus.Data_1;
            mValid = 1'b1;
         end else if (bus.Out_Ready) begin
            mValid = 1'b0;
         end
         if (mOwner < 0) begin
            if (bus.Req_0 && bus.Req_1) mOwner = (mLast == 1) ? 0 : 1;
            else if (bus.Req_0)         mOwner = 0;
            else if (bus.Req_1)         mOwner = 1;
         end else begin
            me       = mOwner;
            reqMe    = (me == 0) ? bus.Req_0 : bus.Req_1;
            reqOther = (me == 0) ? bus.Req_1 : bus.Req_0;
            nb       = mBeats + ((a0 || a1) ? 1 : 0);
            if (nb > MAXB) nb = MAXB;
            if (reqOther && (!reqMe || nb >= MAXB)) begin
               mOwner = 1 - me;
               mLast  = me;
               mBeats = 0;
            end else if (!reqMe && !reqOther) begin
               mOwner = -1;
               mLast  = me;
               mBeats = 0;
            end else begin
               mBeats = nb;
            end
         end
      end
   end

   // Compare every visible output against the model on each falling edge.
   always @(negedge Clk) begin
      if (modelOn) begin
         checkOutput("model Ack_0",     int'(bus.Ack_0),     int'(modelAck(0)));
         checkOutput("model Ack_1",     int'(bus.Ack_1),     int'(modelAck(1)));
         checkOutput("model Out_Valid", int'(bus.Out_Valid), int'(mValid));
         checkOutput("model Out_Data",  int'(bus.Out_Data),  int'(mData));
         checkOutput("model Grant",     int'(bus.Grant),     modelGrant());
         checkOutput("model Select",    int'(bus.Select),    (mOwner == 1) ? 1 : 0);
      end
   end

   // Requester contract: an unacknowledged request keeps its data.
   assert property (@(posedge Clk) disable iff (!Reset_n)
                    (bus.Req_0 && !bus.Ack_0) |=> (bus.Req_0 && $stable(bus.Data_0)))
      else begin
         failures++;
         $display("[TB] FAIL contract requester 0: request or data changed before ack (t=%0t)", $time);
      end

   assert property (@(posedge Clk) disable iff (!Reset_n)
                    (bus.Req_1 && !bus.Ack_1) |=> (bus.Req_1 && $stable(bus.Data_1)))
      else begin
         failures++;
         $display("[TB] FAIL contract requester 1: request or data changed before ack (t=%0t)", $time);
      end

   // Directed scenarios with hand-worked expected values.
   initial begin
      logic [3:0] burstData  [9];
      int         burstGrant [9];
      int         earlyGrant [4];
      burstData  = '{4'h3, 4'h3, 4'h3, 4'h3, 4'hC, 4'hC, 4'hC, 4'hC, 4'h3};
      burstGrant = '{1, 1, 1, 2, 2, 2, 2, 1, 1};
      earlyGrant = '{1, 1, 1, 2};

      applyStimulus(1'b0, 1'b1, 4'h3, 1'b1, 4'hC, 1'b1);
      modelOn = 1'b1;

      // Reset held for two edges with both requesters asking.
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      checkOutput("reset Out_Valid", int'(bus.Out_Valid), 0);
      checkOutput("reset Out_Data",  int'(bus.Out_Data),  0);
      checkOutput("reset Grant",     int'(bus.Grant),     0);
      checkOutput("reset Ack_0",     int'(bus.Ack_0),     0);
      checkOutput("reset Ack_1",     int'(bus.Ack_1),     0);
      #1 applyStimulus(1'b1, 1'b1, 4'h3, 1'b1, 4'hC, 1'b1);
      @(negedge Clk);
      checkOutput("release Grant",     int'(bus.Grant),     1);
      checkOutput("release Ack_0",     int'(bus.Ack_0),     1);
      checkOutput("release Out_Valid", int'(bus.Out_Valid), 0);

      // Burst fairness: four beats each, handover without an idle cycle.
      for (int k = 0; k < 9; k++) begin
         @(negedge Clk);
         checkOutput($sformatf("burst Out_Data[%0d]", k),  int'(bus.Out_Data),  int'(burstData[k]));
         checkOutput($sformatf("burst Out_Valid[%0d]", k), int'(bus.Out_Valid), 1);
         checkOutput($sformatf("burst Grant[%0d]", k),     int'(bus.Grant),     burstGrant[k]);
      end

      // Sole requester: no burst limit, acks continue past four beats.
      #1 resetPulse();
      applyStimulus(1'b1, 1'b1, 4'hA, 1'b0, 4'h0, 1'b1);
      @(negedge Clk);
      checkOutput("single first Grant", int'(bus.Grant), 1);
      checkOutput("single first Ack_0", int'(bus.Ack_0), 1);
      for (int k = 0; k < 6; k++) begin
         @(negedge Clk);
         checkOutput($sformatf("single Out_Data[%0d]", k), int'(bus.Out_Data), (k % 2 == 1) ? 4'h5 : 4'hA);
         checkOutput($sformatf("single Ack_0[%0d]", k),    int'(bus.Ack_0),    1);
         checkOutput($sformatf("single Grant[%0d]", k),    int'(bus.Grant),    1);
         #1 applyStimulus(1'b1, 1'b1, (k % 2 == 1) ? 4'hA : 4'h5, 1'b0, 4'h0, 1'b1);
      end

      // Backpressure: beat 7 held while the consumer stalls.
      resetPulse();
      applyStimulus(1'b1, 1'b1, 4'h7, 1'b0, 4'h0, 1'b1);
      @(negedge Clk);
      checkOutput("bp first Ack_0", int'(bus.Ack_0), 1);
      #1 applyStimulus(1'b1, 1'b1, 4'h7, 1'b0, 4'h0, 1'b0);
      @(negedge Clk);
      checkOutput("bp Out_Valid", int'(bus.Out_Valid), 1);
      checkOutput("bp Out_Data",  int'(bus.Out_Data),  4'h7);
      checkOutput("bp Ack_0",     int'(bus.Ack_0),     0);
      #1 applyStimulus(1'b1, 1'b1, 4'h8, 1'b0, 4'h0, 1'b0);
      repeat (3) begin
         @(negedge Clk);
         checkOutput("bp stall Out_Data",  int'(bus.Out_Data),  4'h7);
         checkOutput("bp stall Out_Valid", int'(bus.Out_Valid), 1);
         checkOutput("bp stall Ack_0",     int'(bus.Ack_0),     0);
      end
      #1 applyStimulus(1'b1, 1'b1, 4'h8, 1'b0, 4'h0, 1'b1);
      #1 checkOutput("bp resume Ack_0", int'(bus.Ack_0), 1);
      @(negedge Clk);
      checkOutput("bp next Out_Data",  int'(bus.Out_Data),  4'h8);
      checkOutput("bp next Out_Valid", int'(bus.Out_Valid), 1);

      // Early release: requester 1 leaves after two beats, 0 takes over.
      #1 resetPulse();
      applyStimulus(1'b1, 1'b0, 4'h0, 1'b1, 4'hE, 1'b1);
      @(negedge Clk);
      checkOutput("early GNT1 Grant", int'(bus.Grant), 2);
      checkOutput("early GNT1 Ack_1", int'(bus.Ack_1), 1);
      #1 applyStimulus(1'b1, 1'b1, 4'h2, 1'b1, 4'hE, 1'b1);
      @(negedge Clk);
      checkOutput("early beat1 Out_Data", int'(bus.Out_Data), 4'hE);
      @(negedge Clk);
      checkOutput("early beat2 Out_Data", int'(bus.Out_Data), 4'hE);
      #1 applyStimulus(1'b1, 1'b1, 4'h2, 1'b0, 4'h0, 1'b1);
      @(negedge Clk);
      checkOutput("early switch Grant",  int'(bus.Grant),  1);
      checkOutput("early switch Select", int'(bus.Select), 0);
      checkOutput("early switch Ack_0",  int'(bus.Ack_0),  1);
      #1 applyStimulus(1'b1, 1'b1, 4'h2, 1'b1, 4'hB, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge Clk);
         checkOutput($sformatf("early fresh burst Grant[%0d]", k), int'(bus.Grant), earlyGrant[k]);
      end

      // Reset while beat 9 is held and the consumer is ready.
      #1 resetPulse();
      applyStimulus(1'b1, 1'b1, 4'h9, 1'b0, 4'h0, 1'b0);
      @(negedge Clk);
      checkOutput("midreset grant Ack_0", int'(bus.Ack_0), 1);
      @(negedge Clk);
      checkOutput("midreset held Out_Valid", int'(bus.Out_Valid), 1);
      checkOutput("midreset held Out_Data",  int'(bus.Out_Data),  4'h9);
      #1 applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
      @(negedge Clk);
      checkOutput("midreset Out_Valid", int'(bus.Out_Valid), 0);
      checkOutput("midreset Out_Data",  int'(bus.Out_Data),  0);
      checkOutput("midreset Grant",     int'(bus.Grant),     0);
      #1 applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
      @(negedge Clk);
      checkOutput("after reset Out_Valid", int'(bus.Out_Valid), 0);
      checkOutput("after reset Grant",     int'(bus.Grant),     0);

      modelOn = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
